prog_loader: RTL and testbench

//  Host-side program loader: the writer for the core's 9-bit instruction memory.

---
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_loader.sv | 115 +++++++++++
 tb/tb_prog_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Host link and instruction-memory write port of the program loader.
// The host/bench drives through the master modport; the loader uses slave.
// Signals: in_valid/in_data/in_ready byte handshake, reload pulse, wr_* memory
// write port, core_reset/load_done/load_err status.
interface prog_loader_if #(
  parameter int IW = 9,
  parameter int AW = 6
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          core_reset;
  logic          load_done;
  logic          load_err;

  modport master (
    output in_valid, in_data, reload,
    input  in_ready, wr_en, wr_addr, wr_data, core_reset, load_done, load_err
  );

  modport slave (
    input  in_valid, in_data, reload,
    output in_ready, wr_en, wr_addr, wr_data, core_reset, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles HDR/LO/HI.../CHK byte frames into 9-bit words and
// writes them to instruction memory, holding the core in reset until a frame
// with a good checksum is complete. One write per instruction, the cycle after
// its HI byte. in_ready is low only in DONE/ERR, where reload restarts loading.
// Ports: clk, reset (sync, active high), bus (slave side of prog_loader_if).
module prog_loader #(
  parameter int IW    = 9,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.slave   bus
);
  // Counter must hold N == DEPTH, one bit wider than the address.
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_LO,
    S_HI,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;
  logic [7:0]    xor_acc;
  logic [7:0]    lo_byte;
  logic          accept;

  assign bus.in_ready = (state != S_DONE) && (state != S_ERR);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_HDR;
      cnt            <= '0;
      addr           <= '0;
      xor_acc        <= '0;
      lo_byte        <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.core_reset <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_err   <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse.
      bus.wr_en <= 1'b0;
      case (state)
        S_HDR: if (accept) begin
          xor_acc <= xor_acc ^ bus.in_data;
          addr    <= '0;
          if (32'(bus.in_data) > DEPTH) begin
            state        <= S_ERR;
            bus.load_err <= 1'b1;
          end else if (bus.in_data == 8'd0) begin
            cnt   <= '0;
            state <= S_CHK;
          end else begin
            cnt   <= CW'(bus.in_data);
            state <= S_LO;
          end
        end
        S_LO: if (accept) begin
          xor_acc <= xor_acc ^ bus.in_data;
          lo_byte <= bus.in_data;
          state   <= S_HI;
        end
        S_HI: if (accept) begin
          if (bus.in_data[7:1] != 7'd0) begin
            // Malformed HI byte: reject without writing.
            state        <= S_ERR;
            bus.load_err <= 1'b1;
          end else begin
            xor_acc     <= xor_acc ^ bus.in_data;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= {bus.in_data[0], lo_byte};
            // Wraps to 0 after the last word of a full-depth frame; unused then.
            addr        <= addr + 1'b1;
            cnt         <= cnt - 1'b1;
            state       <= (cnt == CW'(1)) ? S_CHK : S_LO;
          end
        end
        S_CHK: if (accept) begin
          if (bus.in_data == xor_acc) begin
            state          <= S_DONE;
            bus.core_reset <= 1'b0;
            bus.load_done  <= 1'b1;
          end else begin
            state        <= S_ERR;
            bus.load_err <= 1'b1;
          end
        end
        S_DONE, S_ERR: if (bus.reload) begin
          state          <= S_HDR;
          xor_acc        <= '0;
          bus.core_reset <= 1'b1;
          bus.load_done  <= 1'b0;
          bus.load_err   <= 1'b0;
        end
        default: begin
          state          <= S_ERR;
          bus.core_reset <= 1'b1;
          bus.load_done  <= 1'b0;
          bus.load_err   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives byte frames at the falling edge,
// logs memory writes at the falling edge, and checks status outputs.
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prog_loader_if #(.IW(9), .AW(6)) ifc ();

  prog_loader #(.IW(9), .AW(6), .DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Write log, filled whenever the strobe is seen.
  logic [5:0] wlog_addr[$];
  logic [8:0] wlog_data[$];
  always @(negedge clk) begin
    if (ifc.wr_en === 1'b1) begin
      wlog_addr.push_back(ifc.wr_addr);
      wlog_data.push_back(ifc.wr_data);
    end
  end

  logic [7:0] frm[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] b);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    while (ifc.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 32'(ifc.in_ready), 32'd1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
  endtask

  task automatic send_frm(input int gapmax);
    foreach (frm[i]) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send(frm[i]);
    end
  endtask

  task automatic pulse_reload();
    ifc.reload = 1'b1;
    @(negedge clk);
    ifc.reload = 1'b0;
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic crst,
                            input logic done, input logic err);
    chk({tag, "_in_ready"},   32'(ifc.in_ready),   32'(rdy));
    chk({tag, "_core_reset"}, 32'(ifc.core_reset), 32'(crst));
    chk({tag, "_load_done"},  32'(ifc.load_done),  32'(done));
    chk({tag, "_load_err"},   32'(ifc.load_err),   32'(err));
  endtask

  task automatic chk_frame1(input string tag);
    chk({tag, "_nwrites"}, 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(wlog_addr[0]), 32'd0);
      chk({tag, "_d0"}, 32'(wlog_data[0]), 32'h1A5);
      chk({tag, "_a1"}, 32'(wlog_addr[1]), 32'd1);
      chk({tag, "_d1"}, 32'(wlog_data[1]), 32'h03C);
    end
  endtask

  initial begin
    logic [8:0] code;
    logic [7:0] x;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    ifc.reload   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk_status("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_wr_en",   32'(ifc.wr_en),   32'd0);
    chk("rst_wr_addr", 32'(ifc.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(ifc.wr_data), 32'd0);

    // Good frame 1; core held in reset until CHK accepted
    clear_log();
    frm = '{8'h02, 8'hA5, 8'h01, 8'h3C, 8'h00};
    send_frm(0);
    chk_status("f1_prechk", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h9A);
    chk_status("f1_done", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_frame1("f1");
    pulse_reload();
    chk_status("f1_reload", 1'b1, 1'b1, 1'b0, 1'b0);

    // Bad checksum: writes happen, frame rejected
    clear_log();
    frm = '{8'h02, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9B};
    send_frm(0);
    chk_status("badchk", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_frame1("badchk");
    pulse_reload();

    // Oversized header
    clear_log();
    send(8'h41);
    chk_status("hdr65", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("hdr65_nwrites", 32'(wlog_addr.size()), 32'd0);
    pulse_reload();

    // Bad HI byte; a reload pulse mid-frame must be ignored
    clear_log();
    send(8'h01);
    send(8'hFF);
    pulse_reload();
    chk_status("midreload", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h02);
    @(negedge clk);
    chk_status("badhi", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("badhi_nwrites", 32'(wlog_addr.size()), 32'd0);
    pulse_reload();

    // Empty frame
    clear_log();
    send(8'h00);
    send(8'h00);
    chk_status("empty", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_nwrites", 32'(wlog_addr.size()), 32'd0);
    pulse_reload();

    // Frame 1 with random valid gaps
    clear_log();
    frm = '{8'h02, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
    send_frm(4);
    chk_status("gaps", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_frame1("gaps");
    pulse_reload();

    // Reset mid-frame, with reload asserted at the same time
    clear_log();
    frm = '{8'h02, 8'hA5, 8'h01};
    send_frm(0);
    reset = 1'b1;
    ifc.reload = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ifc.reload = 1'b0;
    chk_status("midrst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrst_wr_en",   32'(ifc.wr_en),   32'd0);
    chk("midrst_wr_addr", 32'(ifc.wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(ifc.wr_data), 32'd0);
    clear_log();
    frm = '{8'h02, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
    send_frm(0);
    chk_status("postrst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_frame1("postrst");

    // Full-depth frame after reload from DONE
    pulse_reload();
    clear_log();
    frm.delete();
    frm.push_back(8'h40);
    x = 8'h40;
    for (int i = 0; i < 64; i++) begin
      code = 9'((i * 37 + 5) & 32'h1FF);
      frm.push_back(code[7:0]);
      frm.push_back({7'd0, code[8]});
      x = x ^ code[7:0] ^ {7'd0, code[8]};
    end
    frm.push_back(x);
    send_frm(0);
    chk_status("full", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_nwrites", 32'(wlog_addr.size()), 32'd64);
    if (wlog_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        chk("full_addr", 32'(wlog_addr[i]), 32'(i));
        chk("full_data", 32'(wlog_data[i]), (i * 37 + 5) & 32'h1FF);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
